// File: rtl/key_disp_pkg.sv
// Shared types and constants for the key scanner / 7-seg display block.
package key_disp_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [2:0] RGB_OFF   = 3'b000;

  typedef struct packed {
    logic       valid;
    logic [3:0] code;
  } hist_entry_t;

  // Active-low {dp,g,f,e,d,c,b,a}; dp stays off.
  function automatic logic [7:0] hex_to_seg(input logic [3:0] hex);
    logic [7:0] seg;
    seg = SEG_BLANK;
    case (hex)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      4'hF: seg = 8'h8E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus counter debouncer for one raw key input.
module key_debounce #(
  parameter int DB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DB_CYCLES);

  logic          sync_a;
  logic          sync_b;
  logic [CW-1:0] cnt;
  logic          flip;

  // flip fires on the DB_CYCLES-th consecutive sample that disagrees with level
  assign flip = (sync_b != level) && (cnt == CW'(DB_CYCLES - 1));
  assign rise = flip && !level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      cnt    <= '0;
      level  <= 1'b0;
    end else begin
      sync_a <= key_raw;
      sync_b <= sync_a;
      if (sync_b == level) begin
        cnt <= '0;
      end else if (flip) begin
        cnt   <= '0;
        level <= ~level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_scan_display.sv
// Debounced key press history shown on a multiplexed 7-seg bank, plus RGB held-key indicator.
// Optional build macro KEY_CHORD_CLEAR_EN: holding every key at once wipes the history.
module key_scan_display
  import key_disp_pkg::*;
#(
  parameter int NUM_KEYS   = 4,
  parameter int NUM_DIGITS = 8,
  parameter int DB_CYCLES  = 1000000,
  parameter int SCAN_DIV   = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_KEYS-1:0]   key,
  output logic [7:0]            cathode,
  output logic [NUM_DIGITS-1:0] anode,
  output logic [2:0]            rgb,
  output logic                  press_stb,
  output logic [3:0]            press_code
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);

  logic [NUM_KEYS-1:0] level;
  logic [NUM_KEYS-1:0] rise;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_db
    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk     (clk),
      .rst_n   (rst_n),
      .key_raw (key[k]),
      .level   (level[k]),
      .rise    (rise[k])
    );
  end

  logic       rise_any;
  logic [3:0] rise_code;
  logic       held_any;
  logic [3:0] held_code;
  logic [2:0] rgb_nxt;
  logic       chord_clr;

  // Descending scan so the lowest index wins for both presses and held keys.
  always_comb begin
    rise_any  = 1'b0;
    rise_code = '0;
    held_any  = 1'b0;
    held_code = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (rise[i]) begin
        rise_any  = 1'b1;
        rise_code = 4'(i);
      end
      if (level[i]) begin
        held_any  = 1'b1;
        held_code = 4'(i);
      end
    end
    rgb_nxt = held_any ? (3'(held_code % 4'd7) + 3'd1) : RGB_OFF;
  end

`ifdef KEY_CHORD_CLEAR_EN
  assign chord_clr = &level;
`else
  assign chord_clr = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_stb  <= 1'b0;
      press_code <= '0;
      rgb        <= RGB_OFF;
    end else begin
      press_stb <= rise_any;
      if (rise_any) press_code <= rise_code;
      rgb <= rgb_nxt;
    end
  end

  hist_entry_t hist [NUM_DIGITS];

  // A pending press is logged before a chord clear, so the chord's own presses show first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < NUM_DIGITS; d++) hist[d] <= '0;
    end else if (press_stb) begin
      hist[0] <= {1'b1, press_code};
      for (int d = 1; d < NUM_DIGITS; d++) hist[d] <= hist[d-1];
    end else if (chord_clr) begin
      for (int d = 0; d < NUM_DIGITS; d++) hist[d].valid <= 1'b0;
    end
  end

  logic [SW-1:0] scan_cnt;
  logic [IW-1:0] scan_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      scan_idx <= '0;
      anode    <= '1;
      cathode  <= SEG_BLANK;
    end else begin
      if (scan_cnt == SW'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        scan_idx <= (scan_idx == IW'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      // anode and cathode both follow the current index, so they switch together
      anode   <= ~(NUM_DIGITS'(1) << scan_idx);
      cathode <= hist[scan_idx].valid ? hex_to_seg(hist[scan_idx].code) : SEG_BLANK;
    end
  end

endmodule
